serial_frame_tx: RTL and testbench

//  Parallel-in/serial-out framed transmitter. It is the transmit end of the serial link

---
 rtl/serial_frame_tx.sv | 149 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Framed parallel-in/serial-out transmitter (start, N data bits
//               MSB- or LSB-first, optional even parity, stop) with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic         msb_first,
    output logic         serial_out,
    output logic         busy,
    output logic         done
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(N - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]          r_state;
    logic [N-1:0]        r_shift;
    logic                r_msb;
    logic                r_parity;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic                r_serial;
    logic                r_done;

    logic [2:0]          w_state_next;
    logic [N-1:0]        w_shift_next;
    logic                w_msb_next;
    logic                w_parity_next;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [c_CNT_W-1:0]  w_bit_cnt_next;
    logic                w_serial_next;
    logic                w_done_next;
    logic                w_baud_end;

    assign w_baud_end = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_msb_next     = r_msb;
        w_parity_next  = r_parity;
        w_baud_next    = r_baud;
        w_bit_cnt_next = r_bit_cnt;
        w_done_next    = 1'b0;

        if (r_state != c_IDLE) begin
            w_baud_next = w_baud_end ? '0 : r_baud + c_BAUD_W'(1);
        end

        case (r_state)
            c_IDLE: begin
                if (data_valid) begin
                    w_state_next   = c_START;
                    w_shift_next   = data_in;
                    w_msb_next     = msb_first;
                    w_parity_next  = ^data_in;
                    w_baud_next    = '0;
                    w_bit_cnt_next = '0;
                end
            end
            c_START: begin
                if (w_baud_end) begin
                    w_state_next   = c_DATA;
                    w_bit_cnt_next = '0;
                end
            end
            c_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == c_CNT_LAST) begin
                        w_state_next = (PARITY_EN != 0) ? c_PARITY : c_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_CNT_W'(1);
                        w_shift_next   = r_msb ? (r_shift << 1) : (r_shift >> 1);
                    end
                end
            end
            c_PARITY: begin
                if (w_baud_end) begin
                    w_state_next = c_STOP;
                end
            end
            c_STOP: begin
                if (w_baud_end) begin
                    w_state_next = c_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase

        // Line level is derived from the upcoming state so the pin itself is a flop.
        case (w_state_next)
            c_START:  w_serial_next = 1'b0;
            c_DATA:   w_serial_next = w_msb_next ? w_shift_next[N-1] : w_shift_next[0];
            c_PARITY: w_serial_next = w_parity_next;
            default:  w_serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_msb     <= 1'b0;
            r_parity  <= 1'b0;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_msb     <= w_msb_next;
            r_parity  <= w_parity_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_serial  <= w_serial_next;
            r_done    <= w_done_next;
        end
    end

    assign data_ready = (r_state == c_IDLE);
    assign busy       = (r_state != c_IDLE);
    assign serial_out = r_serial;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Directed bench for serial_frame_tx across three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       msb_first;
    int         sel;

    logic [2:0] dut_valid;
    logic [2:0] dut_ready, dut_so, dut_busy, dut_done;
    logic       ready, so, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_valid[0] = data_valid && (sel == 0);
    assign dut_valid[1] = data_valid && (sel == 1);
    assign dut_valid[2] = data_valid && (sel == 2);

    assign ready = dut_ready[sel];
    assign so    = dut_so[sel];
    assign busy  = dut_busy[sel];
    assign done  = dut_done[sel];

    serial_frame_tx #(.N(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(dut_valid[0]),
        .data_ready(dut_ready[0]), .msb_first(msb_first), .serial_out(dut_so[0]),
        .busy(dut_busy[0]), .done(dut_done[0])
    );

    serial_frame_tx #(.N(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(dut_valid[1]),
        .data_ready(dut_ready[1]), .msb_first(msb_first), .serial_out(dut_so[1]),
        .busy(dut_busy[1]), .done(dut_done[1])
    );

    serial_frame_tx #(.N(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(dut_valid[2]),
        .data_ready(dut_ready[2]), .msb_first(msb_first), .serial_out(dut_so[2]),
        .busy(dut_busy[2]), .done(dut_done[2])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Sends one word and checks every cycle of the frame plus the done cycle.
    // hold keeps data_valid high during the frame; cont leaves it high in the
    // done cycle so the caller's next frame is accepted back-to-back.
    task automatic frame(input string tag, input int cpb, input int nbits,
                         input logic [15:0] bits, input logic [7:0] word,
                         input logic msb, input bit noise, input bit hold,
                         input bit cont);
        data_in    = word;
        msb_first  = msb;
        data_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) data_valid = 1'b0;
        if (noise) data_in = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                check({tag, "/so"},    so,    bits[nbits-1-i]);
                check({tag, "/busy"},  busy,  1'b1);
                check({tag, "/ready"}, ready, 1'b0);
                check({tag, "/done"},  done,  1'b0);
                if (noise) begin
                    data_valid = (c % 2 == 1) && !(i == nbits - 1 && c == cpb - 1);
                    msb_first  = ~msb_first;
                end
            end
        end
        @(negedge clk);
        check({tag, "/end_done"},  done,  1'b1);
        check({tag, "/end_busy"},  busy,  1'b0);
        check({tag, "/end_so"},    so,    1'b1);
        check({tag, "/end_ready"}, ready, 1'b1);
        if (!cont) begin
            data_valid = 1'b0;
            @(negedge clk);
            check({tag, "/post_done"}, done, 1'b0);
            check({tag, "/post_so"},   so,   1'b1);
        end
    endtask

    initial begin
        sel        = 0;
        reset      = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        msb_first  = 1'b1;

        // Reset and idle line
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst/so",    so,    1'b1);
        check("rst/busy",  busy,  1'b0);
        check("rst/done",  done,  1'b0);
        check("rst/ready", ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle/so", so, 1'b1);
        end

        // 8'hB5: MSB-first 0,1,0,1,1,0,1,0,1,1 ; LSB-first 0,1,0,1,0,1,1,0,1,1
        frame("b5_msb", 1, 10, 16'b0101101011, 8'hB5, 1'b1, 0, 0, 0);
        frame("b5_lsb", 1, 10, 16'b0101011011, 8'hB5, 1'b0, 0, 0, 0);

        // Even parity of 8'hB5 is 1
        sel = 1;
        frame("b5_par", 1, 11, 16'b01011010111, 8'hB5, 1'b1, 0, 0, 0);

        // 8'h0F MSB-first, 4 clocks per bit, with ignored mid-frame traffic
        sel = 2;
        frame("0f_cpb4", 4, 10, 16'b0000011111, 8'h0F, 1'b1, 1, 0, 0);

        // Back-to-back: A5 = 0,1,0,1,0,0,1,0,1,1 ; 3C = 0,0,0,1,1,1,1,0,0,1
        sel = 0;
        frame("a5_b2b", 1, 10, 16'b0101001011, 8'hA5, 1'b1, 0, 1, 1);
        frame("3c_b2b", 1, 10, 16'b0001111001, 8'h3C, 1'b1, 0, 1, 0);

        // Reset during data bit 3 of 8'h5A (MSB-first bit 3 of the frame is 1)
        data_in    = 8'h5A;
        msb_first  = 1'b1;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort/bit3", so, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort/so",    so,    1'b1);
        check("abort/busy",  busy,  1'b0);
        check("abort/ready", ready, 1'b1);
        check("abort/done",  done,  1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort/no_done", done, 1'b0);
        end

        // 8'h81 MSB-first: 0,1,0,0,0,0,0,0,1,1
        frame("81_after", 1, 10, 16'b0100000011, 8'h81, 1'b1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
